// File: rtl/sudoku_grid_dumper_if.sv
// Interface bundle for sudoku_grid_dumper: control, board read port and output stream.
// Ports: start/abort (control in), rd_row/rd_col/rd_data (board read), out_* (valid/ready stream), busy/done (status).
// Modports: master = the dumper, slave = the surrounding logic (board storage, sink, controller).
interface sudoku_grid_dumper_if #(
    parameter int VAL_W = 4
);
    logic             start;
    logic             abort;
    logic [3:0]       rd_row;
    logic [3:0]       rd_col;
    logic [VAL_W-1:0] rd_data;
    logic             out_valid;
    logic             out_ready;
    logic [VAL_W-1:0] out_data;
    logic             out_row_end;
    logic             out_last;
    logic             out_parity;
    logic             busy;
    logic             done;

    modport master (
        input  start, abort, rd_data, out_ready,
        output rd_row, rd_col, out_valid, out_data, out_row_end, out_last,
               out_parity, busy, done
    );

    modport slave (
        output start, abort, rd_data, out_ready,
        input  rd_row, rd_col, out_valid, out_data, out_row_end, out_last,
               out_parity, busy, done
    );
endinterface

// File: rtl/sudoku_grid_dumper.sv
// Purpose: streams the stored N x N board out row-major, one cell per valid/ready handshake.
// Latency: start edge -> busy; next edge -> cell (0,0) valid; back-to-back cells while out_ready=1.
// Backpressure: out_ready=0 freezes out_data, coordinates and the read address; out_valid stays up.
// Ports: clk, rst_n (async active-low), bus (sudoku_grid_dumper_if.master).
// Optional feature: define SUDOKU_DUMP_PARITY_EN to drive out_parity = XOR of out_data bits.
module sudoku_grid_dumper #(
    parameter int N     = 9,
    parameter int VAL_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sudoku_grid_dumper_if.master   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LAST = 4'(N - 1);

    state_t           state;
    logic [3:0]       ptr_row;
    logic [3:0]       ptr_col;
    logic [3:0]       cur_row;
    logic [3:0]       cur_col;
    logic [VAL_W-1:0] data_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;

    logic [3:0]       nxt_row;
    logic [3:0]       nxt_col;
    logic             handshake;
    logic             cur_is_last;

    // Row-major successor of the read pointer, wrapping (N-1,N-1) -> (0,0).
    always_comb begin
        nxt_row = ptr_row;
        nxt_col = ptr_col + 4'd1;
        if (ptr_col == LAST) begin
            nxt_col = 4'd0;
            nxt_row = (ptr_row == LAST) ? 4'd0 : ptr_row + 4'd1;
        end
    end

    assign handshake   = valid_q & bus.out_ready;
    assign cur_is_last = (cur_row == LAST) && (cur_col == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr_row <= 4'd0;
            ptr_col <= 4'd0;
            cur_row <= 4'd0;
            cur_col <= 4'd0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.abort) begin
            // Abort wins over start and over a handshake landing on the same edge.
            state   <= IDLE;
            ptr_row <= 4'd0;
            ptr_col <= 4'd0;
            cur_row <= 4'd0;
            cur_col <= 4'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        ptr_row <= 4'd0;
                        ptr_col <= 4'd0;
                        state   <= FETCH;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                FETCH: begin
                    data_q  <= bus.rd_data;
                    cur_row <= ptr_row;
                    cur_col <= ptr_col;
                    ptr_row <= nxt_row;
                    ptr_col <= nxt_col;
                    valid_q <= 1'b1;
                    state   <= SEND;
                end
                SEND: begin
                    if (handshake) begin
                        if (cur_is_last) begin
                            valid_q <= 1'b0;
                            state   <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            // The pointer already addresses the next cell, so its
                            // value is on rd_data now: refill without a bubble.
                            data_q  <= bus.rd_data;
                            cur_row <= ptr_row;
                            cur_col <= ptr_col;
                            ptr_row <= nxt_row;
                            ptr_col <= nxt_col;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_row      = ptr_row;
    assign bus.rd_col      = ptr_col;
    assign bus.out_valid   = valid_q;
    assign bus.out_data    = data_q;
    assign bus.out_row_end = valid_q & (cur_col == LAST);
    assign bus.out_last    = valid_q & cur_is_last;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

`ifdef SUDOKU_DUMP_PARITY_EN
    assign bus.out_parity  = valid_q & (^data_q);
`else
    assign bus.out_parity  = 1'b0;
`endif

endmodule

// File: tb/tb_sudoku_grid_dumper.sv
// Self-checking bench for sudoku_grid_dumper: directed dumps of known boards with
// hand-derivable cell values, stalls, start-in-SEND/DONE, abort and async reset.
module tb_sudoku_grid_dumper;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   iters;

    logic [3:0] board [0:8][0:8];

    always #5 clk = ~clk;

    sudoku_grid_dumper_if #(.VAL_W(4)) bus ();

    sudoku_grid_dumper #(.N(9), .VAL_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Board storage model: combinational read at the DUT's registered address.
    always_comb begin
        bus.rd_data = 4'd0;
        if (bus.rd_row < 4'd9 && bus.rd_col < 4'd9)
            bus.rd_data = board[int'(bus.rd_row)][int'(bus.rd_col)];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_par(input logic [3:0] d);
`ifdef SUDOKU_DUMP_PARITY_EN
        return ^d;
`else
        return 1'b0 & d[0];
`endif
    endfunction

    task automatic load_pattern();
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                board[r][c] = 4'(((r * 3 + r / 3 + c) % 9) + 1);
    endtask

    task automatic load_sparse();
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                board[r][c] = 4'd0;
        board[8][8] = 4'd13;
    endtask

    // Consumes cells until stop_after handshakes are scheduled; the last one
    // lands on the posedge following return. start is pulsed on iteration start_iter.
    task automatic run_stream(input bit rnd, input int stop_after, input int start_iter,
                              output int n_iter);
        int         hs;
        bit         stalled;
        logic [3:0] held;
        logic [3:0] e;
        hs      = 0;
        n_iter  = 0;
        stalled = 1'b0;
        held    = 4'd0;
        while (hs < stop_after && n_iter < 1000) begin
            @(negedge clk);
            n_iter++;
            if (stalled) begin
                chk("stall_valid", 32'(bus.out_valid), 32'd1);
                chk("stall_data", 32'(bus.out_data), 32'(held));
            end
            bus.start     = (n_iter == start_iter);
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.out_valid && bus.out_ready) begin
                e = board[hs / 9][hs % 9];
                chk("cell_data", 32'(bus.out_data), 32'(e));
                chk("row_end", 32'(bus.out_row_end), 32'((hs % 9) == 8));
                chk("last", 32'(bus.out_last), 32'(hs == 80));
                chk("parity", 32'(bus.out_parity), 32'(exp_par(e)));
                hs++;
            end
            stalled = bus.out_valid && !bus.out_ready;
            held    = bus.out_data;
        end
        if (hs < stop_after)
            chk("stream_timeout", 32'(hs), 32'(stop_after));
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_busy", 32'(bus.busy), 32'd1);
        chk("start_done", 32'(bus.done), 32'd0);
        chk("fetch_valid", 32'(bus.out_valid), 32'd0);
    endtask

    task automatic check_done();
        @(negedge clk);
        chk("end_done", 32'(bus.done), 32'd1);
        chk("end_busy", 32'(bus.busy), 32'd0);
        chk("end_valid", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        load_pattern();

        // Reset state
        #12;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_row", 32'(bus.rd_row), 32'd0);
        chk("rst_col", 32'(bus.rd_col), 32'd0);
        chk("rst_last", 32'(bus.out_last), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 32'd0);

        // Full-rate dump: 81 consecutive cycles of transfers, done 82 edges after start
        pulse_start();
        run_stream(1'b0, 81, -1, iters);
        chk("back_to_back_iters", 32'(iters), 32'd81);
        check_done();

        // start from DONE, plus a start pulse mid-SEND that must be ignored
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("restart_busy", 32'(bus.busy), 32'd1);
        chk("restart_done", 32'(bus.done), 32'd0);
        run_stream(1'b0, 81, 30, iters);
        chk("start_in_send_iters", 32'(iters), 32'd81);
        check_done();

        // Random backpressure
        pulse_start();
        run_stream(1'b1, 81, -1, iters);
        check_done();

        // Sparse board: only the final cell is non-zero
        load_sparse();
        pulse_start();
        run_stream(1'b0, 81, -1, iters);
        check_done();

        // Abort together with start on the 40th handshake edge
        load_pattern();
        pulse_start();
        run_stream(1'b0, 40, -1, iters);
        bus.abort = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk("abort_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_rd_row", 32'(bus.rd_row), 32'd0);
        chk("abort_rd_col", 32'(bus.rd_col), 32'd0);
        chk("abort_last", 32'(bus.out_last), 32'd0);
        @(negedge clk);
        chk("abort_stays_idle", 32'(bus.busy), 32'd0);
        pulse_start();
        run_stream(1'b0, 81, -1, iters);
        check_done();

        // Asynchronous reset in the middle of a dump
        pulse_start();
        run_stream(1'b0, 20, -1, iters);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_data", 32'(bus.out_data), 32'd0);
        chk("arst_row_end", 32'(bus.out_row_end), 32'd0);
        chk("arst_last", 32'(bus.out_last), 32'd0);
        chk("arst_parity", 32'(bus.out_parity), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_rd_row", 32'(bus.rd_row), 32'd0);
        chk("arst_rd_col", 32'(bus.rd_col), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(bus.busy), 32'd0);
        chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("post_rst_done", 32'(bus.done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
